// File: rtl/clock_sim_pkg.sv
// Shared definitions for the time-of-day clock slice.
// Contents: BCD digit widths, set-field select encodings, reset time
// constants and a BCD hour increment helper used by the hours logic.
package clock_sim_pkg;

    localparam int HR_TENS_W  = 2;
    localparam int MIN_TENS_W = 3;
    localparam int SEC_TENS_W = 3;
    localparam int ONES_W     = 4;

    // set_sel encodings
    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_HR  = 1'b1;

    // Reset hours as packed BCD {tens[1:0], ones[3:0]}
    localparam logic [5:0] RST_HR_24 = 6'h00;
    localparam logic [5:0] RST_HR_12 = 6'h12;
    localparam logic [3:0] RST_ZERO  = 4'd0;

    // Plain BCD +1 on a packed hour; range wrap is handled by the caller.
    function automatic logic [5:0] bcd_hr_inc(input logic [5:0] hr);
        logic [5:0] r;
        if (hr[3:0] == 4'd9) begin
            r = {hr[5:4] + 2'd1, 4'd0};
        end else begin
            r = {hr[5:4], hr[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (used for seconds and minutes).
// Counts 00..MAX_TENS:MAX_ONES and wraps to 00.
// Ports:
//   clock, reset  posedge clock, async active-low reset to 00
//   inc           advance by one
//   clr           force 00 (wins over inc, never carries)
//   tens, ones    registered BCD digits
//   carry         combinational: inc is wrapping the counter this cycle
module bcd_mod_counter
    import clock_sim_pkg::*;
#(
    parameter int TENS_W   = 3,
    parameter int MAX_TENS = 5,
    parameter int MAX_ONES = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [TENS_W-1:0] tens,
    output logic [3:0]        ones,
    output logic              carry
);

    logic [TENS_W-1:0] tens_q, tens_d;
    logic [3:0]        ones_q, ones_d;
    logic              at_max;

    assign at_max = (tens_q == TENS_W'(MAX_TENS)) && (ones_q == 4'(MAX_ONES));

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        carry  = 1'b0;
        if (clr) begin
            tens_d = '0;
            ones_d = RST_ZERO;
        end else if (inc) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = RST_ZERO;
                carry  = 1'b1;
            end else if (ones_q == 4'd9) begin
                tens_d = tens_q + 1'b1;
                ones_d = 4'd0;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tens_q <= '0;
            ones_q <= RST_ZERO;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/time_of_day_counter.sv
// Wall-clock time keeper: counts divider tick edges as seconds and keeps
// BCD hh:mm:ss, with a set-time mode for manual hour/minute adjustment.
// Ports:
//   clock, reset        posedge clock, async active-low reset
//   tick_in             divider square wave (one rising edge per second)
//   run                 enables time advance
//   set_mode/set_sel    set-time mode and field select (0 min, 1 hr)
//   inc_pulse           increment selected field while in set mode
//   hr_*/min_*/sec_*    BCD time digits
//   pm                  PM flag in 12h mode, 0 otherwise
//   sec_pulse, day_wrap one-cycle strobes on second advance / day rollover
module time_of_day_counter
    import clock_sim_pkg::*;
#(
    parameter int MODE_12H = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick_in,
    input  logic                  run,
    input  logic                  set_mode,
    input  logic                  set_sel,
    input  logic                  inc_pulse,
    output logic [HR_TENS_W-1:0]  hr_tens,
    output logic [ONES_W-1:0]     hr_ones,
    output logic [MIN_TENS_W-1:0] min_tens,
    output logic [ONES_W-1:0]     min_ones,
    output logic [SEC_TENS_W-1:0] sec_tens,
    output logic [ONES_W-1:0]     sec_ones,
    output logic                  pm,
    output logic                  sec_pulse,
    output logic                  day_wrap
);

    localparam logic [5:0] HR_RST = (MODE_12H != 0) ? RST_HR_12 : RST_HR_24;

    logic       tick_q, tick_d;
    logic       set_q, set_d;
    logic [5:0] hr_q, hr_d;
    logic       pm_q, pm_d;
    logic       sec_pulse_q, sec_pulse_d;
    logic       day_wrap_q, day_wrap_d;

    logic tick_rise, advance, set_rise;
    logic inc_set, min_inc, hr_inc_tick, hr_inc, hr_wrap;
    logic sec_carry, min_carry;

    // tick_q resets high so a divider that idles high after reset gives no edge
    assign tick_rise = tick_in & ~tick_q;
    assign advance   = tick_rise & run & ~set_mode;
    assign set_rise  = set_mode & ~set_q;
    assign inc_set   = set_mode & inc_pulse;

    // Minutes move on a seconds carry or a manual minute increment. The two
    // never coincide (advance needs set_mode=0), so min_carry into hours is
    // qualified by advance to keep manual increments from carrying.
    assign min_inc     = (advance & sec_carry) | (inc_set & (set_sel == SEL_MIN));
    assign hr_inc_tick = advance & sec_carry & min_carry;
    assign hr_inc      = hr_inc_tick | (inc_set & (set_sel == SEL_HR));

    bcd_mod_counter #(
        .TENS_W  (SEC_TENS_W),
        .MAX_TENS(5),
        .MAX_ONES(9)
    ) u_sec (
        .clock(clock),
        .reset(reset),
        .inc  (advance),
        .clr  (set_rise),
        .tens (sec_tens),
        .ones (sec_ones),
        .carry(sec_carry)
    );

    bcd_mod_counter #(
        .TENS_W  (MIN_TENS_W),
        .MAX_TENS(5),
        .MAX_ONES(9)
    ) u_min (
        .clock(clock),
        .reset(reset),
        .inc  (min_inc),
        .clr  (1'b0),
        .tens (min_tens),
        .ones (min_ones),
        .carry(min_carry)
    );

    always_comb begin
        tick_d      = tick_in;
        set_d       = set_mode;
        hr_d        = hr_q;
        pm_d        = pm_q;
        hr_wrap     = 1'b0;
        if (hr_inc) begin
            if (MODE_12H != 0) begin
                if (hr_q == 6'h12) begin
                    hr_d = 6'h01;
                end else if (hr_q == 6'h11) begin
                    // 11->12 flips AM/PM; leaving PM means the day rolled over
                    hr_d    = 6'h12;
                    pm_d    = ~pm_q;
                    hr_wrap = pm_q;
                end else begin
                    hr_d = bcd_hr_inc(hr_q);
                end
            end else if (hr_q == 6'h23) begin
                hr_d    = 6'h00;
                hr_wrap = 1'b1;
            end else begin
                hr_d = bcd_hr_inc(hr_q);
            end
        end
        sec_pulse_d = advance;
        // manual hour increments never report a day rollover
        day_wrap_d  = hr_inc_tick & hr_wrap;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q      <= 1'b1;
            set_q       <= 1'b0;
            hr_q        <= HR_RST;
            pm_q        <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            set_q       <= set_d;
            hr_q        <= hr_d;
            pm_q        <= pm_d;
            sec_pulse_q <= sec_pulse_d;
            day_wrap_q  <= day_wrap_d;
        end
    end

    assign hr_tens   = hr_q[5:4];
    assign hr_ones   = hr_q[3:0];
    assign pm        = pm_q;
    assign sec_pulse = sec_pulse_q;
    assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: a 24h and a 12h instance share inputs and
// are both compared every cycle against a seconds-of-day model.
module tb_time_of_day_counter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tick_in = 1'b1, run = 1'b1, set_mode = 1'b0, set_sel = 1'b0, inc_pulse = 1'b0;

    logic [1:0] a_ht, b_ht;
    logic [3:0] a_ho, b_ho, a_mo, b_mo, a_so, b_so;
    logic [2:0] a_mt, b_mt, a_st, b_st;
    logic       a_pm, b_pm, a_sp, b_sp, a_dw, b_dw;

    always #5 clock = ~clock;

    time_of_day_counter #(.MODE_12H(0)) dut24 (
        .clock(clock), .reset(reset), .tick_in(tick_in), .run(run),
        .set_mode(set_mode), .set_sel(set_sel), .inc_pulse(inc_pulse),
        .hr_tens(a_ht), .hr_ones(a_ho), .min_tens(a_mt), .min_ones(a_mo),
        .sec_tens(a_st), .sec_ones(a_so), .pm(a_pm), .sec_pulse(a_sp), .day_wrap(a_dw));

    time_of_day_counter #(.MODE_12H(1)) dut12 (
        .clock(clock), .reset(reset), .tick_in(tick_in), .run(run),
        .set_mode(set_mode), .set_sel(set_sel), .inc_pulse(inc_pulse),
        .hr_tens(b_ht), .hr_ones(b_ho), .min_tens(b_mt), .min_ones(b_mo),
        .sec_tens(b_st), .sec_ones(b_so), .pm(b_pm), .sec_pulse(b_sp), .day_wrap(b_dw));

    logic [23:0] t24, t12;
    assign t24 = {2'b00, a_ht, a_ho, 1'b0, a_mt, a_mo, 1'b0, a_st, a_so};
    assign t12 = {2'b00, b_ht, b_ho, 1'b0, b_mt, b_mo, 1'b0, b_st, b_so};

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model: time as h/m/s integers ----------------
    int m_h = 0, m_m = 0, m_s = 0;
    bit m_tq = 1'b1, m_sq = 1'b0, e_sp = 1'b0, e_dw = 1'b0;
    int m_tot, m_tn;
    bit m_adv, m_wrap;

    assign m_adv  = tick_in && !m_tq && run && !set_mode;
    assign m_tot  = m_h * 3600 + m_m * 60 + m_s + 1;
    assign m_wrap = (m_tot == 86400);
    assign m_tn   = m_wrap ? 0 : m_tot;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_h <= 0; m_m <= 0; m_s <= 0;
            m_tq <= 1'b1; m_sq <= 1'b0; e_sp <= 1'b0; e_dw <= 1'b0;
        end else begin
            if (m_adv) begin
                m_h <= m_tn / 3600;
                m_m <= (m_tn / 60) % 60;
                m_s <= m_tn % 60;
            end else if (set_mode) begin
                if (!m_sq) m_s <= 0;
                if (inc_pulse) begin
                    if (set_sel) m_h <= (m_h + 1) % 24;
                    else         m_m <= (m_m + 1) % 60;
                end
            end
            e_sp <= m_adv;
            e_dw <= m_adv && m_wrap;
            m_tq <= tick_in;
            m_sq <= set_mode;
        end
    end

    function automatic logic [26:0] exp_vec(input bit mode12);
        int hr;
        hr = mode12 ? (((m_h % 12) == 0) ? 12 : (m_h % 12)) : m_h;
        return {2'b00, 2'(hr / 10), 4'(hr % 10), 1'b0, 3'(m_m / 10), 4'(m_m % 10),
                1'b0, 3'(m_s / 10), 4'(m_s % 10), (mode12 && (m_h >= 12)), e_sp, e_dw};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            total++;
            if ({t24, a_pm, a_sp, a_dw} !== exp_vec(1'b0)) begin
                bad++;
                $display("FAIL cmp24 got=%h exp=%h t=%0t", {t24, a_pm, a_sp, a_dw}, exp_vec(1'b0), $time);
            end
            total++;
            if ({t12, b_pm, b_sp, b_dw} !== exp_vec(1'b1)) begin
                bad++;
                $display("FAIL cmp12 got=%h exp=%h t=%0t", {t12, b_pm, b_sp, b_dw}, exp_vec(1'b1), $time);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // one rising edge on tick_in; returns just after the edge that consumes it
    task automatic tick_one();
        tick_in = 1'b0;
        step();
        tick_in = 1'b1;
        step();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick_one();
    endtask

    task automatic set_time(input int th, input int tm);
        inc_pulse = 1'b0;
        set_mode  = 1'b1;
        step();
        set_sel = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (m_h == th) break;
            inc_pulse = 1'b1;
            step();
        end
        inc_pulse = 1'b0;
        set_sel   = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (m_m == tm) break;
            inc_pulse = 1'b1;
            step();
        end
        inc_pulse = 1'b0;
        set_mode  = 1'b0;
        step();
    endtask

    initial begin
        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (3) step();
        reset = 1'b1;

        // reset state with tick_in idling high: no edge, no pulse
        repeat (5) step();
        @(negedge clock);
        lit("rst24", t24, 24'h000000);
        lit("rst12", t12, 24'h120000);
        lit("rst_flags", {a_sp, a_dw, b_pm, b_sp}, 0);

        // 00:00:58 -> 59 -> 00:01:00
        set_time(0, 0);
        ticks(58);
        tick_one();
        @(negedge clock);
        lit("s59", t24, 24'h000059);
        lit("sp_on", a_sp, 1);
        tick_one();
        @(negedge clock);
        lit("m01", t24, 24'h000100);

        // day rollover
        set_time(23, 59);
        ticks(59);
        @(negedge clock);
        lit("pre_wrap12", {t12, b_pm}, {24'h115959, 1'b1});
        tick_one();
        @(negedge clock);
        lit("wrap24", t24, 24'h000000);
        lit("dw24", a_dw, 1);
        lit("wrap12", {t12, b_pm, b_dw}, {24'h120000, 1'b0, 1'b1});
        @(negedge clock);
        lit("dw_off", {a_dw, b_dw}, 0);

        // 12h: 11:59:59 AM -> 12:00:00 PM, 12:59:59 PM -> 01:00:00 PM
        set_time(11, 59);
        ticks(59);
        tick_one();
        @(negedge clock);
        lit("noon12", {t12, b_pm, b_dw}, {24'h120000, 1'b1, 1'b0});
        set_time(12, 59);
        ticks(59);
        tick_one();
        @(negedge clock);
        lit("one_pm12", {t12, b_pm}, {24'h010000, 1'b1});
        lit("one_pm24", t24, 24'h130000);

        // set mode at 10:20:33
        set_time(10, 20);
        ticks(33);
        @(negedge clock);
        lit("t102033", t24, 24'h102033);
        set_mode = 1'b1;
        set_sel  = 1'b0;
        step();
        @(negedge clock);
        lit("sec_clr", t24, 24'h102000);
        repeat (40) begin
            inc_pulse = 1'b1;
            step();
        end
        inc_pulse = 1'b0;
        ticks(3);
        @(negedge clock);
        lit("inc40", t24, 24'h100000);
        lit("no_sp_set", a_sp, 0);

        // set_mode rise and inc_pulse in the same cycle
        set_mode = 1'b0;
        step();
        ticks(5);
        set_mode  = 1'b1;
        inc_pulse = 1'b1;
        step();
        inc_pulse = 1'b0;
        @(negedge clock);
        lit("simul", t24, 24'h100100);
        set_mode = 1'b0;
        step();
        inc_pulse = 1'b1;
        step();
        inc_pulse = 1'b0;
        @(negedge clock);
        lit("inc_ign", t24, 24'h100100);
        run = 1'b0;
        ticks(2);
        @(negedge clock);
        lit("run0", t24, 24'h100100);
        run = 1'b1;

        // async reset mid-count at 05:06:07
        set_time(5, 6);
        ticks(7);
        @(negedge clock);
        lit("t050607", t24, 24'h050607);
        #2 reset = 1'b0;
        #1;
        lit("arst24", t24, 24'h000000);
        lit("arst12", {t12, b_pm}, {24'h120000, 1'b0});
        step();
        step();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            lit("post_rst", {a_sp, a_dw, b_sp, b_dw}, 0);
        end

        // randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            tick_in   = 1'($urandom_range(0, 1));
            run       = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) set_mode = ~set_mode;
            set_sel   = 1'($urandom_range(0, 1));
            inc_pulse = ($urandom_range(0, 3) == 0);
            step();
        end
        @(negedge clock);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
